// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-window target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic        ACK_LEVEL     = 1'b0;
  localparam logic        NACK_LEVEL    = 1'b1;

endpackage

// File: rtl/i2c_input_filter.sv
// Bus input conditioning: 2-flop synchronizer, optional persistence filter
// (I2C_TARGET_GLITCH_FILTER_EN), and registered rise/fall flags aligned with level_o.
module i2c_input_filter
`ifdef I2C_TARGET_GLITCH_FILTER_EN
#(
  parameter int unsigned FILTER_LEN = 3
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       levelD;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;

  // The bus idles high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], in_i};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_LEN) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else if (sync_q[1] == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      stable_q <= sync_q[1];
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign levelD = stable_q;
`else
  assign levelD = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= levelD;
      rise_q  <= levelD & ~level_q;
      fall_q  <= ~levelD & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a pointer-addressed byte register window; no clock stretching.
// Build option: I2C_TARGET_GLITCH_FILTER_EN adds a FILTER_LEN-sample input filter.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned REG_AW      = 4
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILTER_LEN  = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_t,
  output logic              reg_wr_valid,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [7:0]        reg_rd_data,
  output logic              busy,
  output logic              selected
);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;

  i2c_input_filter
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    uSclFilter (
      .clk(clk), .rst(rst), .in_i(scl_i),
      .level_o(sclLevel), .rise_o(sclRise), .fall_o(sclFall)
    );

  i2c_input_filter
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    uSdaFilter (
      .clk(clk), .rst(rst), .in_i(sda_i),
      .level_o(sdaLevel), .rise_o(sdaRise), .fall_o(sdaFall)
    );

  state_e            state_q;
  logic [3:0]        bitCnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        rdShift_q;
  logic [REG_AW-1:0] ptr_q;
  logic [REG_AW-1:0] wrAddr_q;
  logic [7:0]        wrData_q;
  logic              rw_q;
  logic              sdaT_q;
  logic              wrValid_q;
  logic              busy_q;
  logic              selected_q;

  logic       startDet, stopDet, lastBit, byteDone;
  logic [7:0] rxByte;

  assign startDet = sdaFall & sclLevel;
  assign stopDet  = sdaRise & sclLevel;
  assign rxByte   = {shift_q[6:0], sdaLevel};
  assign lastBit  = (bitCnt_q == 4'(BITS_PER_BYTE - 1));
  assign byteDone = (bitCnt_q == 4'(BITS_PER_BYTE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      rdShift_q  <= '0;
      ptr_q      <= '0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rw_q       <= 1'b0;
      sdaT_q     <= 1'b1;
      wrValid_q  <= 1'b0;
      busy_q     <= 1'b0;
      selected_q <= 1'b0;
    end else begin
      wrValid_q <= 1'b0;
      if (startDet) begin
        state_q    <= ADDR;
        bitCnt_q   <= '0;
        sdaT_q     <= 1'b1;
        busy_q     <= 1'b1;
        selected_q <= 1'b0;
      end else if (stopDet) begin
        state_q    <= IDLE;
        sdaT_q     <= 1'b1;
        busy_q     <= 1'b0;
        selected_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WR_DATA: begin
            if (sclRise && !byteDone) begin
              shift_q  <= rxByte;
              bitCnt_q <= bitCnt_q + 1'b1;
              if (lastBit && state_q == PTR) ptr_q <= rxByte[REG_AW-1:0];
              if (lastBit && state_q == WR_DATA) begin
                wrValid_q <= 1'b1;
                wrAddr_q  <= ptr_q;
                wrData_q  <= rxByte;
                ptr_q     <= ptr_q + 1'b1;
              end
            end else if (sclFall && byteDone) begin
              bitCnt_q <= '0;
              if (state_q == ADDR) begin
                if (shift_q[7:1] == TARGET_ADDR) begin
                  sdaT_q     <= ACK_LEVEL;
                  selected_q <= 1'b1;
                  rw_q       <= shift_q[0];
                  state_q    <= ADDR_ACK;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end else begin
                sdaT_q  <= ACK_LEVEL;
                state_q <= (state_q == PTR) ? PTR_ACK : WR_ACK;
              end
            end
          end
          // ADDR_ACK and an ACKed RD_ACK share the read-byte load on the closing SCL fall.
          ADDR_ACK, RD_ACK: begin
            if (sclRise && state_q == RD_ACK) begin
              shift_q <= rxByte;
            end else if (sclFall) begin
              if ((state_q == ADDR_ACK && rw_q) ||
                  (state_q == RD_ACK && shift_q[0] == ACK_LEVEL)) begin
                rdShift_q <= {reg_rd_data[6:0], 1'b0};
                sdaT_q    <= reg_rd_data[7];
                ptr_q     <= ptr_q + 1'b1;
                bitCnt_q  <= '0;
                state_q   <= RD_DATA;
              end else begin
                sdaT_q  <= NACK_LEVEL;
                state_q <= (state_q == ADDR_ACK) ? PTR : WAIT_STOP;
              end
            end
          end
          PTR_ACK, WR_ACK: begin
            if (sclFall) begin
              sdaT_q  <= 1'b1;
              state_q <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (sclRise && !byteDone) begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end else if (sclFall) begin
              if (byteDone) begin
                sdaT_q   <= 1'b1;
                bitCnt_q <= '0;
                state_q  <= RD_ACK;
              end else begin
                sdaT_q    <= rdShift_q[7];
                rdShift_q <= {rdShift_q[6:0], 1'b0};
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda_o        = 1'b0;
  assign sda_t        = sdaT_q;
  assign reg_wr_valid = wrValid_q;
  assign reg_wr_addr  = wrAddr_q;
  assign reg_wr_data  = wrData_q;
  assign reg_rd_addr  = ptr_q;
  assign busy         = busy_q;
  assign selected     = selected_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged master, wired-AND SDA, register-window model.
// Filter-only glitch sequence is compiled when I2C_TARGET_GLITCH_FILTER_EN is defined.
module tb_i2c_target_regs;

  localparam int         Q          = 10;
  localparam logic [6:0] TargetAddr = 7'h50;

  typedef struct {
    string       name;
    logic        isRead;
    logic [6:0]  addr;
    logic [7:0]  ptr;
    int          nBytes;
    logic [3:0][7:0] data;
    logic        fromTable;
    int          expStrobes;
    int          expPtr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaBus;
  logic       sdaO, sdaT;
  logic       regWrValid;
  logic [3:0] regWrAddr, regRdAddr;
  logic [7:0] regWrData, regRdData;
  logic       busy, selected;

  logic [7:0]  fabricRegs [16];
  logic [7:0]  modelRegs [16];
  logic        fabricReady = 1'b0;
  logic [11:0] strobeLog [256];
  int          strobeCnt = 0;
  int          modelPtr;
  int          compared = 0;
  int          mismatched = 0;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(sclM), .sda_i(sdaBus),
    .sda_o(sdaO), .sda_t(sdaT),
    .reg_wr_valid(regWrValid), .reg_wr_addr(regWrAddr), .reg_wr_data(regWrData),
    .reg_rd_addr(regRdAddr), .reg_rd_data(regRdData),
    .busy(busy), .selected(selected)
  );

  always #5 clk = ~clk;

  assign sdaBus    = sdaM & (sdaT | sdaO);
  assign regRdData = fabricRegs[regRdAddr];

  function automatic logic [7:0] initVal(input int i);
    return 8'(i * 29 + 7);
  endfunction

  // Register fabric behind the target, plus a log of every write strobe.
  always @(posedge clk) begin
    if (!fabricReady) begin
      for (int i = 0; i < 16; i++) fabricRegs[i] <= initVal(i);
    end else if (regWrValid) begin
      fabricRegs[regWrAddr] <= regWrData;
    end
    if (regWrValid && strobeCnt < 256) begin
      strobeLog[strobeCnt] <= {regWrAddr, regWrData};
      strobeCnt <= strobeCnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clockBit(input logic b, output logic s);
    waitCycles(Q); sdaM = b;
    waitCycles(Q); sclM = 1'b1;
    waitCycles(Q); s = sdaBus;
    waitCycles(Q); sclM = 1'b0;
  endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  task automatic clockBitGlitch(input logic b);
    waitCycles(Q); sdaM = b;
    waitCycles(Q); sclM = 1'b1;
    waitCycles(Q); sclM = 1'b0;
    waitCycles(1); sclM = 1'b1;
    waitCycles(Q); sclM = 1'b0;
  endtask
`endif

  task automatic i2cStart();
    sdaM = 1'b1; waitCycles(Q);
    sclM = 1'b1; waitCycles(Q);
    sdaM = 1'b0; waitCycles(Q);
    sclM = 1'b0;
  endtask

  task automatic i2cStop();
    waitCycles(Q); sdaM = 1'b0;
    waitCycles(Q); sclM = 1'b1;
    waitCycles(Q); sdaM = 1'b1;
    waitCycles(2 * Q);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(d[i], s);
    clockBit(1'b1, ack);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      d[i] = s;
    end
    clockBit(nack, s);
  endtask

  function automatic vec_t mkVec(input string name, input logic isRead, input logic [6:0] addr,
                                 input logic [7:0] ptr, input int n, input logic [31:0] data,
                                 input int expStrobes, input int expPtr);
    vec_t v;
    v.name = name; v.isRead = isRead; v.addr = addr; v.ptr = ptr; v.nBytes = n;
    v.data = data; v.fromTable = 1'b1; v.expStrobes = expStrobes; v.expPtr = expPtr;
    return v;
  endfunction

  // One full transaction; expectations come from the register-window model.
  task automatic applyStimulus(input vec_t v);
    logic        ack, match;
    logic [7:0]  rd;
    int          startIdx;
    logic [11:0] expQ [$];
    match    = (v.addr == TargetAddr);
    startIdx = strobeCnt;
    i2cStart();
    writeByte({v.addr, 1'b0}, ack);
    checkOutput({v.name, ".addrAck"}, ack, match ? 0 : 1);
    checkOutput({v.name, ".selected"}, selected, match);
    checkOutput({v.name, ".busy"}, busy, 1);
    writeByte(v.ptr, ack);
    checkOutput({v.name, ".ptrAck"}, ack, match ? 0 : 1);
    if (match) modelPtr = v.ptr % 16;
    if (!v.isRead) begin
      for (int i = 0; i < v.nBytes; i++) begin
        writeByte(v.data[i], ack);
        checkOutput({v.name, ".dataAck"}, ack, match ? 0 : 1);
        if (match) begin
          modelRegs[modelPtr] = v.data[i];
          expQ.push_back({4'(modelPtr), v.data[i]});
          modelPtr = (modelPtr + 1) % 16;
        end
      end
    end else if (match) begin
      i2cStart();
      writeByte({v.addr, 1'b1}, ack);
      checkOutput({v.name, ".rdAddrAck"}, ack, 0);
      for (int i = 0; i < v.nBytes; i++) begin
        readByte(i == v.nBytes - 1, rd);
        checkOutput({v.name, ".rdData"}, rd, modelRegs[modelPtr]);
        modelPtr = (modelPtr + 1) % 16;
      end
    end
    if (!match) begin
      checkOutput({v.name, ".busyNoMatch"}, busy, 1);
      checkOutput({v.name, ".selNoMatch"}, selected, 0);
    end
    i2cStop();
    checkOutput({v.name, ".busyIdle"}, busy, 0);
    checkOutput({v.name, ".selIdle"}, selected, 0);
    checkOutput({v.name, ".sdaReleased"}, sdaT, 1);
    checkOutput({v.name, ".strobeCount"}, strobeCnt - startIdx, expQ.size());
    for (int i = 0; i < expQ.size() && startIdx + i < strobeCnt; i++)
      checkOutput({v.name, ".strobe"}, strobeLog[startIdx + i], expQ[i]);
    checkOutput({v.name, ".pointer"}, regRdAddr, modelPtr);
    if (v.fromTable) begin
      checkOutput({v.name, ".tblStrobes"}, strobeCnt - startIdx, v.expStrobes);
      checkOutput({v.name, ".tblPtr"}, regRdAddr, v.expPtr);
    end
  endtask

  initial begin
    vec_t tbl [6];
    vec_t v;
    logic ack;
    tbl[0] = mkVec("wr_a5",    1'b0, 7'h50, 8'h03, 1, 32'h000000A5, 1, 4);
    tbl[1] = mkVec("wr_wrap",  1'b0, 7'h50, 8'h0E, 3, 32'h00332211, 3, 1);
    tbl[2] = mkVec("ptr_hi",   1'b0, 7'h50, 8'hF2, 1, 32'h00000077, 1, 3);
    tbl[3] = mkVec("wr_5a_c3", 1'b0, 7'h50, 8'h05, 2, 32'h0000C35A, 2, 7);
    tbl[4] = mkVec("rd_2",     1'b1, 7'h50, 8'h05, 2, 32'h00000000, 0, 7);
    tbl[5] = mkVec("nack_51",  1'b0, 7'h51, 8'h02, 1, 32'h000000FF, 0, 7);
    for (int i = 0; i < 16; i++) modelRegs[i] = initVal(i);
    modelPtr = 0;

    waitCycles(4);
    fabricReady = 1'b1;
    checkOutput("rst.sdaT", sdaT, 1);
    checkOutput("rst.sdaO", sdaO, 0);
    checkOutput("rst.wrValid", regWrValid, 0);
    checkOutput("rst.wrAddr", regWrAddr, 0);
    checkOutput("rst.wrData", regWrData, 0);
    checkOutput("rst.rdAddr", regRdAddr, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.selected", selected, 0);
    rst = 1'b1;
    waitCycles(Q);

    for (int i = 0; i < 6; i++) applyStimulus(tbl[i]);

    // Reset while the target drives the first read bit (regs[5] = 0x5A, MSB 0).
    i2cStart();
    writeByte({TargetAddr, 1'b0}, ack);
    writeByte(8'h05, ack);
    modelPtr = 5;
    i2cStart();
    writeByte({TargetAddr, 1'b1}, ack);
    checkOutput("midRst.addrAck", ack, 0);
    waitCycles(Q);
    checkOutput("midRst.drivenBit", sdaT, modelRegs[5][7]);
    checkOutput("midRst.selected", selected, 1);
    rst = 1'b0;
    #1;
    checkOutput("midRst.sdaT", sdaT, 1);
    checkOutput("midRst.busy", busy, 0);
    checkOutput("midRst.selected0", selected, 0);
    waitCycles(3);
    rst = 1'b1;
    modelPtr = 0;
    sdaM = 1'b1;
    i2cStop();
    checkOutput("midRst.ptr", regRdAddr, 0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    begin
      int startIdx;
      logic [7:0] d;
      startIdx = strobeCnt;
      d = 8'h3C;
      i2cStart();
      writeByte({TargetAddr, 1'b0}, ack);
      writeByte(8'h09, ack);
      for (int i = 7; i >= 0; i--) begin
        if (i == 4) clockBitGlitch(d[i]);
        else clockBit(d[i], ack);
      end
      clockBit(1'b1, ack);
      checkOutput("glitch.dataAck", ack, 0);
      i2cStop();
      modelRegs[9] = d;
      modelPtr = 10;
      checkOutput("glitch.strobeCount", strobeCnt - startIdx, 1);
      checkOutput("glitch.strobe", strobeLog[startIdx], {4'h9, d});
      checkOutput("glitch.ptr", regRdAddr, modelPtr);
    end
`endif

    for (int k = 0; k < 10; k++) begin
      v.name      = "rand";
      v.isRead    = 1'($urandom_range(0, 1));
      v.addr      = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TargetAddr;
      v.ptr       = 8'($urandom);
      v.nBytes    = $urandom_range(1, 4);
      v.data      = 32'($urandom);
      v.fromTable = 1'b0;
      v.expStrobes = 0;
      v.expPtr    = 0;
      applyStimulus(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) that presents a small byte-wide register window to an external I2C master on the same open-drain SCL/SDA pair driven by the team's `i2c_master`. It oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit address, ACKs, and performs pointer-addressed register writes and auto-incrementing reads through a simple fabric-side register port. It sits at the board-facing edge of the attitude-indicator design, exposing configuration and status registers to an off-chip controller or a loopback master under test.

## Interface
- `TARGET_ADDR`, 7'h50: 7-bit I2C address the block responds to.
- `REG_AW`, 4: register pointer width; window is 2^REG_AW bytes.
- `FILTER_LEN`, 3: consecutive equal samples required by the input filter (with the filter macro only).

- `clk`  in  1  system clock (25 MHz nominal).
- `rst`  in  1  asynchronous, active-low reset.
- `scl_i`  in  1  SCL bus level.
- `sda_i`  in  1  SDA bus level.
- `sda_o`  out  1  SDA drive value; constant 0 (open-drain).
- `sda_t`  out  1  SDA tristate; 1 = released, 0 = pull low.
- `reg_wr_valid`  out  1  one-cycle write strobe.
- `reg_wr_addr`  out  REG_AW  write register index.
- `reg_wr_data`  out  8  write data.
- `reg_rd_addr`  out  REG_AW  read register index (current pointer).
- `reg_rd_data`  in  8  read data for `reg_rd_addr`, valid combinationally or registered within 1 cycle.
- `busy`  out  1  high from START to STOP, any address.
- `selected`  out  1  high while this target is addressed (ACKed address through STOP/next START).

## Operation
- Reset values: `sda_o`=0, `sda_t`=1, `reg_wr_valid`=0, `reg_wr_addr`=0, `reg_wr_data`=0, `reg_rd_addr`=0, `busy`=0, `selected`=0, state IDLE, pointer 0.
- SCL/SDA pass through a 2-flop synchronizer; edges derived from the synchronized (and filtered, if enabled) levels.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. START/STOP take priority over all state logic in every state; START (incl. repeated) -> ADDR, bit count 0, SDA released; STOP -> IDLE, SDA released, `busy`/`selected` cleared.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- Bits are sampled on SCL rising edge, MSB first; SDA is changed only on SCL falling edge.
- ADDR: 8 bits shifted. Address match -> ADDR_ACK (pull SDA low for the 9th clock), `selected`=1; R/W=0 -> PTR, R/W=1 -> RD_DATA. Mismatch -> WAIT_STOP, SDA never driven.
- PTR: received byte loads pointer (low REG_AW bits; upper bits ignored), ACK, then WR_DATA.
- WR_DATA: each byte ACKed; `reg_wr_valid` pulses once with `reg_wr_addr`=pointer, `reg_wr_data`=byte, on the cycle the 8th bit is sampled; pointer increments.
- RD_DATA: shift register loaded from `reg_rd_data` at the SCL falling edge that ends ADDR_ACK or an ACKed RD_ACK; pointer increments after load. SDA released on the falling edge ending the 8th bit.
- RD_ACK: master ACK (0) -> next byte; NACK (1) -> WAIT_STOP.
- Pointer wraps modulo 2^REG_AW on both paths. Pointer persists across transactions (write-ptr then repeated-START read works).
- No clock stretching; SCL is never driven.

## Timing
- Input latency: 2 cycles (synchronizer) + FILTER_LEN cycles with filter.
- SDA drive/release: 1 cycle after detected SCL falling edge.
- Requirement: master SCL low phase ≥ 16 `clk` cycles and SDA hold after SCL fall ≥ input latency + 2 cycles; with `prescale`=63 on the master both are met.
- START and a simultaneous SCL edge in the same cycle: START wins.
- Reset asserted mid-transfer: SDA released immediately (async), all state to reset values.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN` defined: each input passes a FILTER_LEN-sample persistence filter after the synchronizer; pulses shorter than FILTER_LEN cycles are suppressed.
- Undefined: synchronizer only; `FILTER_LEN` unused.

## Structure
- Package `i2c_target_pkg`: state enum, I2C bit-count constant (8), ACK/NACK level constants.
- Sub-module `i2c_input_filter` (sync + optional filter + registered rise/fall flags), instantiated for SCL and SDA.

## Test plan
- Write 0x50, ptr 0x03, data 0xA5, STOP -> ACK on all 3 bytes; one `reg_wr_valid` with addr 3, data 0xA5; `busy`/`selected` low after STOP.
- Write ptr 0x0E, data 0x11,0x22,0x33 -> strobes at addr 0xE, 0xF, 0x0 (wrap).
- Write ptr 0x05, repeated START, read 2 bytes with ACK then NACK, regs[5]=0x5A, regs[6]=0xC3 -> master receives 0x5A,0xC3; target releases SDA; pointer = 7.
- Address 0x51 write -> NACK (SDA released at 9th clock), no strobes, `selected`=0, `busy`=1 until STOP.
- Assert `rst` mid data byte -> `sda_t`=1 same cycle; next full transaction completes normally.
- With filter: 1-cycle low glitch on SCL during data phase -> no bit shifted; without filter, same glitch corrupts data (documented).
